// File: rtl/mc_controller.sv
// Multi-cycle MIPS-style controller: one registered state, every control
// output decoded combinationally from the state and the live inputs.
module mc_controller #(
   parameter logic [5:0] HALT_OP = 6'b111111
) (
   input  logic       CLK,
   input  logic       Reset,
   input  logic [5:0] Opcode,
   input  logic [5:0] Funct,
   input  logic       Zero,
   input  logic       InsReady,
   input  logic       DataReady,
   output logic       PCWre,
   output logic [1:0] PCSrc,
   output logic       IRWre,
   output logic       ExtSel,
   output logic       ALUSrcB,
   output logic [2:0] ALUOp,
   output logic       RegWre,
   output logic       RegDst,
   output logic       DBDataSrc,
   output logic       mRD,
   output logic       mWR,
   output logic [3:0] State,
   output logic       Halted
);

   localparam logic [3:0] S_IF     = 4'd0;
   localparam logic [3:0] S_ID     = 4'd1;
   localparam logic [3:0] S_EXE_AL = 4'd2;
   localparam logic [3:0] S_EXE_BR = 4'd3;
   localparam logic [3:0] S_EXE_LS = 4'd4;
   localparam logic [3:0] S_MEM    = 4'd5;
   localparam logic [3:0] S_WB_AL  = 4'd6;
   localparam logic [3:0] S_WB_LD  = 4'd7;
   localparam logic [3:0] S_HALT   = 4'd8;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   logic [3:0] state_reg;
   logic [3:0] state_next;

   logic       is_r;
   logic       is_addi;
   logic       is_ori;
   logic       is_lw;
   logic       is_sw;
   logic       is_beq;
   logic       is_j;
   logic       is_halt;
   logic       funct_ok;
   logic [2:0] r_aluop;
   logic       dec_ext;
   logic       dec_srcb;
   logic [2:0] dec_aluop;

   // Instruction decode: classify the opcode and derive the datapath controls
   // that stay constant for the whole instruction after fetch.
   always_comb begin
      funct_ok = 1'b1;
      r_aluop  = 3'b000;
      case (Funct)
         6'b100000: r_aluop = 3'b000;
         6'b100010: r_aluop = 3'b001;
         6'b100100: r_aluop = 3'b010;
         6'b100101: r_aluop = 3'b011;
         6'b000000: r_aluop = 3'b100;
         6'b101010: r_aluop = 3'b101;
         default:   funct_ok = 1'b0;
      endcase
      // HALT_OP is checked first so a custom halt opcode always wins.
      is_halt = (Opcode == HALT_OP);
      is_r    = !is_halt && (Opcode == OP_RTYPE) && funct_ok;
      is_addi = !is_halt && (Opcode == OP_ADDI);
      is_ori  = !is_halt && (Opcode == OP_ORI);
      is_lw   = !is_halt && (Opcode == OP_LW);
      is_sw   = !is_halt && (Opcode == OP_SW);
      is_beq  = !is_halt && (Opcode == OP_BEQ);
      is_j    = !is_halt && (Opcode == OP_J);
      dec_ext  = is_addi | is_lw | is_sw | is_beq;
      dec_srcb = is_addi | is_ori | is_lw | is_sw;
      if (is_r)
         dec_aluop = r_aluop;
      else if (is_beq)
         dec_aluop = 3'b001;
      else if (is_ori)
         dec_aluop = 3'b011;
      else
         dec_aluop = 3'b000;
   end

   // State register; reset dominates every transition.
   always_ff @(posedge CLK) begin
      if (Reset)
         state_reg <= S_IF;
      else
         state_reg <= state_next;
   end

   // Next-state logic.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IF:     if (InsReady) state_next = S_ID;
         S_ID: begin
            if (is_halt)
               state_next = S_HALT;
            else if (is_r || is_addi || is_ori)
               state_next = S_EXE_AL;
            else if (is_beq)
               state_next = S_EXE_BR;
            else if (is_lw || is_sw)
               state_next = S_EXE_LS;
            else
               state_next = S_IF;   // j, illegal opcode, unknown funct
         end
         S_EXE_AL: state_next = S_WB_AL;
         S_EXE_BR: state_next = S_IF;
         S_EXE_LS: state_next = S_MEM;
         S_MEM: begin
            if (DataReady)
               state_next = is_lw ? S_WB_LD : S_IF;
         end
         S_WB_AL:  state_next = S_IF;
         S_WB_LD:  state_next = S_IF;
         S_HALT:   state_next = S_HALT;
         default:  state_next = S_IF;
      endcase
   end

   // Output decode from state and live inputs; reset forces everything quiet.
   always_comb begin
      PCWre     = 1'b0;
      PCSrc     = 2'b00;
      IRWre     = 1'b0;
      ExtSel    = 1'b0;
      ALUSrcB   = 1'b0;
      ALUOp     = 3'b000;
      RegWre    = 1'b0;
      RegDst    = 1'b0;
      DBDataSrc = 1'b0;
      mRD       = 1'b0;
      mWR       = 1'b0;
      Halted    = 1'b0;
      // Datapath selects stay stable from decode until the instruction retires.
      if (state_reg != S_IF && state_reg != S_HALT) begin
         ExtSel  = dec_ext;
         ALUSrcB = dec_srcb;
         ALUOp   = dec_aluop;
      end
      case (state_reg)
         S_IF: begin
            if (InsReady) begin
               PCWre = 1'b1;
               IRWre = 1'b1;
            end
         end
         S_ID: begin
            if (is_j) begin
               PCWre = 1'b1;
               PCSrc = 2'b10;
            end
         end
         S_EXE_BR: begin
            if (Zero) begin
               PCWre = 1'b1;
               PCSrc = 2'b01;
            end
         end
         S_MEM: begin
            mRD = is_lw;
            mWR = is_sw;
         end
         S_WB_AL: begin
            RegWre = 1'b1;
            RegDst = is_r;
         end
         S_WB_LD: begin
            RegWre    = 1'b1;
            DBDataSrc = 1'b1;
         end
         S_HALT:  Halted = 1'b1;
         default: ;
      endcase
      if (Reset) begin
         PCWre     = 1'b0;
         PCSrc     = 2'b00;
         IRWre     = 1'b0;
         ExtSel    = 1'b0;
         ALUSrcB   = 1'b0;
         ALUOp     = 3'b000;
         RegWre    = 1'b0;
         RegDst    = 1'b0;
         DBDataSrc = 1'b0;
         mRD       = 1'b0;
         mWR       = 1'b0;
         Halted    = 1'b0;
      end
   end

   assign State = state_reg;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: a per-instruction model expands each instruction
// into its expected cycle-by-cycle control vector, and the bench replays it.
module tb_mc_controller;

   localparam logic [5:0] HALT_OP = 6'b111111;

   logic       CLK = 1'b0;
   logic       Reset;
   logic [5:0] Opcode;
   logic [5:0] Funct;
   logic       Zero;
   logic       InsReady;
   logic       DataReady;
   logic       PCWre;
   logic [1:0] PCSrc;
   logic       IRWre;
   logic       ExtSel;
   logic       ALUSrcB;
   logic [2:0] ALUOp;
   logic       RegWre;
   logic       RegDst;
   logic       DBDataSrc;
   logic       mRD;
   logic       mWR;
   logic [3:0] State;
   logic       Halted;

   mc_controller #(.HALT_OP(HALT_OP)) dut (
      .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
      .InsReady(InsReady), .DataReady(DataReady), .PCWre(PCWre), .PCSrc(PCSrc),
      .IRWre(IRWre), .ExtSel(ExtSel), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .RegWre(RegWre), .RegDst(RegDst), .DBDataSrc(DBDataSrc), .mRD(mRD),
      .mWR(mWR), .State(State), .Halted(Halted)
   );

   always #5 CLK = ~CLK;

   // Observed vector: State, PCWre, PCSrc, IRWre, ExtSel, ALUSrcB, ALUOp,
   // RegWre, RegDst, DBDataSrc, mRD, mWR, Halted.
   logic [18:0] obs;
   assign obs = {State, PCWre, PCSrc, IRWre, ExtSel, ALUSrcB, ALUOp,
                 RegWre, RegDst, DBDataSrc, mRD, mWR, Halted};

   typedef struct {
      logic [5:0]  op;
      logic [5:0]  funct;
      logic        zero;
      logic        ins;
      logic        data;
      logic        rst;
      logic [18:0] exp;
   } cyc_t;

   cyc_t sched[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc_no = 0;

   function automatic bit rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [18:0] pk(input int st, input bit pcw, input bit [1:0] pcs,
                                      input bit irw, input bit ext, input bit srcb,
                                      input bit [2:0] aop, input bit rw, input bit rd,
                                      input bit dbs, input bit mrd, input bit mwr,
                                      input bit hlt);
      logic [3:0] s4;
      s4 = 4'(st);
      return {s4, pcw, pcs, irw, ext, srcb, aop, rw, rd, dbs, mrd, mwr, hlt};
   endfunction

   function automatic void push(input logic [5:0] op, input logic [5:0] fn, input bit z,
                                input bit ins, input bit data, input bit rst,
                                input logic [18:0] exp);
      cyc_t c;
      c.op = op; c.funct = fn; c.zero = z; c.ins = ins; c.data = data;
      c.rst = rst; c.exp = exp;
      sched.push_back(c);
   endfunction

   // Expand one instruction into its expected cycles. iw = InsReady-low cycles
   // in fetch, dw = DataReady-low cycles in the memory phase.
   function automatic void model_instr(input logic [5:0] op, input logic [5:0] fn,
                                       input bit z, input int iw, input int dw);
      bit rok, r, addi, ori, lw, sw, beq, j, ext, srcb;
      bit [2:0] raop, aop;
      rok = 1'b1;
      raop = 3'd0;
      case (fn)
         6'b100000: raop = 3'd0;
         6'b100010: raop = 3'd1;
         6'b100100: raop = 3'd2;
         6'b100101: raop = 3'd3;
         6'b000000: raop = 3'd4;
         6'b101010: raop = 3'd5;
         default:   rok = 1'b0;
      endcase
      r    = (op == 6'b000000) && rok;
      addi = (op == 6'b001000);
      ori  = (op == 6'b001101);
      lw   = (op == 6'b100011);
      sw   = (op == 6'b101011);
      beq  = (op == 6'b000100);
      j    = (op == 6'b000010);
      ext  = addi | lw | sw | beq;
      srcb = addi | ori | lw | sw;
      aop  = r ? raop : beq ? 3'd1 : ori ? 3'd3 : 3'd0;
      for (int i = 0; i < iw; i++)
         push(op, fn, rb(), 1'b0, rb(), 1'b0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      push(op, fn, rb(), 1'b1, rb(), 1'b0, pk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      push(op, fn, rb(), rb(), rb(), 1'b0,
           pk(1, j, j ? 2'd2 : 2'd0, 0, ext, srcb, aop, 0, 0, 0, 0, 0, 0));
      if (r || addi || ori) begin
         push(op, fn, rb(), rb(), rb(), 1'b0, pk(2, 0, 0, 0, ext, srcb, aop, 0, 0, 0, 0, 0, 0));
         push(op, fn, rb(), rb(), rb(), 1'b0, pk(6, 0, 0, 0, ext, srcb, aop, 1, r, 0, 0, 0, 0));
      end else if (beq) begin
         push(op, fn, z, rb(), rb(), 1'b0,
              pk(3, z, z ? 2'd1 : 2'd0, 0, ext, srcb, aop, 0, 0, 0, 0, 0, 0));
      end else if (lw || sw) begin
         push(op, fn, rb(), rb(), rb(), 1'b0, pk(4, 0, 0, 0, ext, srcb, aop, 0, 0, 0, 0, 0, 0));
         for (int i = 0; i < dw; i++)
            push(op, fn, rb(), rb(), 1'b0, 1'b0, pk(5, 0, 0, 0, ext, srcb, aop, 0, 0, 0, lw, sw, 0));
         push(op, fn, rb(), rb(), 1'b1, 1'b0, pk(5, 0, 0, 0, ext, srcb, aop, 0, 0, 0, lw, sw, 0));
         if (lw)
            push(op, fn, rb(), rb(), rb(), 1'b0, pk(7, 0, 0, 0, ext, srcb, aop, 1, 0, 1, 0, 0, 0));
      end
   endfunction

   // Apply one cycle of inputs, sample outputs at the falling edge.
   task automatic step(input cyc_t c, output logic [18:0] o);
      Opcode = c.op; Funct = c.funct; Zero = c.zero;
      InsReady = c.ins; DataReady = c.data; Reset = c.rst;
      @(negedge CLK);
      o = obs;
      @(posedge CLK);
      #1;
      cyc_no++;
   endtask

   task automatic test_reset();
      cyc_t c; logic [18:0] o;
      for (int i = 0; i < 4; i++)
         push(6'($urandom), 6'($urandom), 1'b1, 1'b1, 1'b1, 1'b1,
              pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      push(6'b000000, 6'b100000, 1'b0, 1'b0, 1'b0, 1'b0,
           pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      while (sched.size() > 0) begin
         c = sched.pop_front(); step(c, o); n_cmp++;
         if (o !== c.exp) begin
            n_bad++;
            $display("FAIL reset cyc=%0d: got %h expected %h", cyc_no, o, c.exp);
         end
      end
      $display("test_reset done");
   endtask

   task automatic test_rtype_add();
      cyc_t c; logic [18:0] o;
      model_instr(6'b000000, 6'b100000, 1'b0, 0, 0);
      while (sched.size() > 0) begin
         c = sched.pop_front(); step(c, o); n_cmp++;
         if (o !== c.exp) begin
            n_bad++;
            $display("FAIL rtype_add cyc=%0d: got %h expected %h", cyc_no, o, c.exp);
         end
      end
      $display("test_rtype_add done");
   endtask

   task automatic test_imm();
      cyc_t c; logic [18:0] o;
      model_instr(6'b001101, 6'($urandom), 1'b0, 0, 0);
      model_instr(6'b001000, 6'($urandom), 1'b0, 1, 0);
      while (sched.size() > 0) begin
         c = sched.pop_front(); step(c, o); n_cmp++;
         if (o !== c.exp) begin
            n_bad++;
            $display("FAIL imm cyc=%0d: got %h expected %h", cyc_no, o, c.exp);
         end
      end
      $display("test_imm ori/addi done");
   endtask

   task automatic test_lw_wait();
      cyc_t c; logic [18:0] o; int n;
      model_instr(6'b100011, 6'($urandom), 1'b0, 0, 3);
      n = 0;
      while (sched.size() > 0) begin
         c = sched.pop_front(); step(c, o); n_cmp++; n++;
         if (o !== c.exp) begin
            n_bad++;
            $display("FAIL lw_wait cyc=%0d: got %h expected %h", cyc_no, o, c.exp);
         end
      end
      n_cmp++;
      if (n !== 8) begin
         n_bad++;
         $display("FAIL lw_wait_len: got %0d cycles expected 8", n);
      end
      $display("test_lw_wait done, %0d cycles", n);
   endtask

   task automatic test_beq();
      cyc_t c; logic [18:0] o;
      model_instr(6'b000100, 6'($urandom), 1'b1, 0, 0);
      model_instr(6'b000100, 6'($urandom), 1'b0, 0, 0);
      while (sched.size() > 0) begin
         c = sched.pop_front(); step(c, o); n_cmp++;
         if (o !== c.exp) begin
            n_bad++;
            $display("FAIL beq cyc=%0d: got %h expected %h", cyc_no, o, c.exp);
         end
      end
      $display("test_beq taken/not-taken done");
   endtask

   task automatic test_jump_illegal();
      cyc_t c; logic [18:0] o;
      model_instr(6'b000010, 6'($urandom), 1'b0, 0, 0);
      model_instr(6'b010101, 6'($urandom), 1'b0, 0, 0);
      model_instr(6'b000000, 6'b111111, 1'b0, 0, 0);
      while (sched.size() > 0) begin
         c = sched.pop_front(); step(c, o); n_cmp++;
         if (o !== c.exp) begin
            n_bad++;
            $display("FAIL jump_illegal cyc=%0d: got %h expected %h", cyc_no, o, c.exp);
         end
      end
      $display("test_jump_illegal done");
   endtask

   task automatic test_random();
      cyc_t c; logic [18:0] o;
      logic [5:0] op, fn;
      logic [5:0] legal_fn [6];
      legal_fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b000000, 6'b101010};
      for (int k = 0; k < 40; k++) begin
         fn = 6'($urandom);
         case ($urandom_range(0, 8))
            0: begin op = 6'b000000; fn = legal_fn[$urandom_range(0, 5)]; end
            1: op = 6'b001000;
            2: op = 6'b001101;
            3: op = 6'b100011;
            4: op = 6'b101011;
            5: op = 6'b000100;
            6: op = 6'b000010;
            7: begin
               op = 6'($urandom);
               while (op == 6'b000000 || op == 6'b001000 || op == 6'b001101 ||
                      op == 6'b100011 || op == 6'b101011 || op == 6'b000100 ||
                      op == 6'b000010 || op == HALT_OP)
                  op = 6'($urandom);
            end
            default: begin
               op = 6'b000000;
               while (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                 6'b000000, 6'b101010})
                  fn = 6'($urandom);
            end
         endcase
         model_instr(op, fn, rb(), $urandom_range(0, 2), $urandom_range(0, 3));
         while (sched.size() > 0) begin
            c = sched.pop_front(); step(c, o); n_cmp++;
            if (o !== c.exp) begin
               n_bad++;
               $display("FAIL random op=%b fn=%b cyc=%0d: got %h expected %h",
                        op, fn, cyc_no, o, c.exp);
            end
         end
         $display("random instr %0d op=%b fn=%b done", k, op, fn);
      end
   endtask

   task automatic test_reset_mid_mem();
      cyc_t c; logic [18:0] o;
      model_instr(6'b101011, 6'($urandom), 1'b0, 0, 2);
      c = sched.pop_back();
      c.rst = 1'b1;
      c.data = 1'b1;
      c.exp = pk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      sched.push_back(c);
      push(6'b101011, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      while (sched.size() > 0) begin
         c = sched.pop_front(); step(c, o); n_cmp++;
         if (o !== c.exp) begin
            n_bad++;
            $display("FAIL reset_mid_mem cyc=%0d: got %h expected %h", cyc_no, o, c.exp);
         end
      end
      $display("test_reset_mid_mem done");
   endtask

   task automatic test_halt();
      cyc_t c; logic [18:0] o;
      model_instr(HALT_OP, 6'($urandom), 1'b0, 0, 0);
      for (int i = 0; i < 12; i++)
         push(HALT_OP, 6'd0, rb(), 1'b1, rb(), 1'b0, pk(8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      push(HALT_OP, 6'd0, 1'b1, 1'b1, 1'b1, 1'b1, pk(8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      push(HALT_OP, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      while (sched.size() > 0) begin
         c = sched.pop_front(); step(c, o); n_cmp++;
         if (o !== c.exp) begin
            n_bad++;
            $display("FAIL halt cyc=%0d: got %h expected %h", cyc_no, o, c.exp);
         end
      end
      $display("test_halt done");
   endtask

   initial begin
      Reset = 1'b1; Opcode = 6'd0; Funct = 6'd0; Zero = 1'b0;
      InsReady = 1'b0; DataReady = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      test_reset();
      test_rtype_add();
      test_imm();
      test_lw_wait();
      test_beq();
      test_jump_illegal();
      test_random();
      test_reset_mid_mem();
      test_halt();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter HALT_OP, default 6'b111111, opcode that sends the FSM to HALT.
REQ-002 CLK  input  1  sole clock, all state changes on posedge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Opcode  input  6  IR[31:26], held stable by IR outside IF.
REQ-005 Funct  input  6  IR[5:0], R-type function field.
REQ-006 Zero  input  1  ALU zero flag, valid in EXE_BR.
REQ-007 InsReady  input  1  instruction memory has data for the current fetch.
REQ-008 DataReady  input  1  data memory has completed the current access.
REQ-009 PCWre  output  1  PC load enable.
REQ-010 PCSrc  output  2  00 PC+4, 01 branch target, 10 jump target.
REQ-011 IRWre  output  1  IR load enable.
REQ-012 ExtSel  output  1  0 zero-extend imm16, 1 sign-extend imm16.
REQ-013 ALUSrcB  output  1  0 register rt, 1 extended immediate.
REQ-014 ALUOp  output  3  000 add, 001 sub, 010 and, 011 or, 100 sll, 101 slt.
REQ-015 RegWre  output  1  register-file write enable.
REQ-016 RegDst  output  1  0 rt, 1 rd as write register.
REQ-017 DBDataSrc  output  1  0 ALU result, 1 memory data to write-back.
REQ-018 mRD / mWR  output  1 each  data-memory read / write strobes.
REQ-019 State  output  4  current state encoding, for debug.
REQ-020 Halted  output  1  high while in HALT.

Function
REQ-021 States, encoding: IF=0, ID=1, EXE_AL=2, EXE_BR=3, EXE_LS=4, MEM=5, WB_AL=6, WB_LD=7, HALT=8; only State is registered; all other outputs are decoded combinationally from State, Opcode, Funct, Zero, InsReady and DataReady.
REQ-022 Decoded ops: R-type 000000 (Funct 100000 add, 100010 sub, 100100 and, 100101 or, 000000 sll, 101010 slt), addi 001000, ori 001101, lw 100011, sw 101011, beq 000100, j 000010, HALT_OP.
REQ-023 IF: wait while InsReady=0 with all enables low; when InsReady=1: IRWre=1, PCWre=1, PCSrc=00, next ID.
REQ-024 ID: R-type/addi/ori -> EXE_AL; beq -> EXE_BR; lw/sw -> EXE_LS; j -> IF with PCWre=1, PCSrc=10 in ID; HALT_OP -> HALT; any other opcode or unlisted R-type Funct -> IF with no enables (treated as NOP).
REQ-025 ExtSel=0 for ori, 1 for addi/lw/sw/beq, 0 otherwise; ExtSel and ALUSrcB/ALUOp hold their decoded value in every state after IF so the datapath sees them stable.
REQ-026 EXE_AL: ALUSrcB=0 for R-type, 1 for addi/ori; ALUOp from Funct (R-type), 000 addi, 011 ori; next WB_AL.
REQ-027 WB_AL: RegWre=1, RegDst=1 for R-type else 0, DBDataSrc=0; next IF.
REQ-028 EXE_BR: ALUOp=001, ALUSrcB=0; if Zero=1: PCWre=1, PCSrc=01; next IF regardless.
REQ-029 EXE_LS: ALUOp=000, ALUSrcB=1, ExtSel=1; next MEM.
REQ-030 MEM: mRD=1 (lw) or mWR=1 (sw) held until DataReady=1; on DataReady: lw -> WB_LD, sw -> IF.
REQ-031 WB_LD: RegWre=1, RegDst=0, DBDataSrc=1; next IF.
REQ-032 HALT: all enables low, Halted=1, remains until Reset.
REQ-033 Latency with ready signals tied high: R-type/addi/ori 4, lw 5, sw 4, beq 3, j 2 cycles; each wait cycle adds one.
REQ-034 PCWre, IRWre, RegWre, mRD, mWR never assert in the same cycle as another of that set except PCWre with IRWre in IF.

Reset
REQ-035 Reset=1 at a posedge forces State=IF regardless of current state, including mid-MEM wait or HALT; Reset dominates all transitions.
REQ-036 While Reset=1 all enables and strobes are forced 0, Halted=0, PCSrc=00, ALUOp=000, ExtSel=0.

Verification
REQ-037 Reset, ready high, R-type add (Funct 100000) -> states 0,1,2,6,0; RegWre=1 RegDst=1 only in state 6; ALUOp=000.
REQ-038 ori then addi -> ExtSel=0 during ori EXE_AL, ExtSel=1 during addi EXE_AL; ALUSrcB=1 both.
REQ-039 lw, DataReady low 3 cycles in MEM -> mRD=1 for 4 cycles, then WB_LD with DBDataSrc=1 RegWre=1; total 8 cycles.
REQ-040 beq Zero=1 -> PCWre=1 PCSrc=01 in EXE_BR; beq Zero=0 -> PCWre=0, both return to IF after 3 cycles.
REQ-041 j -> PCWre=1 PCSrc=10 in ID, back to IF; illegal opcode 010101 -> ID then IF, no enables.
REQ-042 HALT_OP -> Halted=1 for 10+ cycles, no enables; Reset asserted mid-MEM for sw -> next state IF, mWR=0 that cycle.
